// File: rtl/game_pkg.sv
// Shared game-flow types: stage codes, sequencer states, level-range helper.
// Consumed by stage_sequencer and the blocks that decode its stage output.
package game_pkg;

  localparam logic [3:0] STAGE_TITLE = 4'h0;
  localparam logic [3:0] STAGE_WIN   = 4'hE;
  localparam logic [3:0] STAGE_OVER  = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } seq_state_e;

  function automatic logic is_level(
    input logic [3:0] s,
    input logic [3:0] last
  );
    return (s != STAGE_TITLE) && (s <= last);
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Key/lives/clear inputs and stage outputs of the game-flow sequencer.
// master drives the player-side inputs; slave is the sequencer itself.
interface stage_sequencer_if;

  logic       ENTER_signal;
  logic       P_signal;
  logic [3:0] lives;
  logic       stage_clear;
  logic [3:0] stage;
  logic       stage_start;
  logic       holding;
  logic       paused;

  modport master (
    output ENTER_signal, P_signal, lives, stage_clear,
    input  stage, stage_start, holding, paused
  );

  modport slave (
    input  ENTER_signal, P_signal, lives, stage_clear,
    output stage, stage_start, holding, paused
  );

endinterface

// File: rtl/key_edge.sv
// 1-bit rising-edge detector, sync active-low reset.
// Previous level resets to 1 so a key held through reset gives no edge.
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst) prev_q <= 1'b1;
    else      prev_q <= key_i;
  end

  assign rise_o = key_i & ~prev_q;

endmodule

// File: rtl/stage_sequencer.sv
// Title -> levels -> win/over sequencer with timed hold between screens.
// Define PAUSE_EN to enable P-key pause toggling during PLAY.
module stage_sequencer
  import game_pkg::*;
#(
  parameter int               TIMER_W     = 24,
  parameter logic [3:0]       LAST_STAGE  = 4'd3,
  parameter logic [TIMER_W-1:0] HOLD_CYCLES = TIMER_W'(200)
) (
  input  logic              clk,
  input  logic              rst,
  stage_sequencer_if.slave  bus
);

  seq_state_e         state_q, state_d;
  logic [3:0]         stage_q, stage_d;
  logic [3:0]         target_q, target_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               start_q, start_d;
  logic               armed_q, armed_d;
  logic               enter_rise;
  logic               play_go;

  key_edge u_enter (
    .clk    (clk),
    .rst    (rst),
    .key_i  (bus.ENTER_signal),
    .rise_o (enter_rise)
  );

`ifdef PAUSE_EN
  logic p_rise;
  logic paused_q, paused_d;

  key_edge u_p (
    .clk    (clk),
    .rst    (rst),
    .key_i  (bus.P_signal),
    .rise_o (p_rise)
  );

  always_ff @(posedge clk) begin
    if (!rst) paused_q <= 1'b0;
    else      paused_q <= paused_d;
  end

  // A P edge wins over any PLAY trigger in the same cycle
  always_comb begin
    paused_d = 1'b0;
    play_go  = 1'b1;
    if (state_q == PLAY) begin
      paused_d = p_rise ? ~paused_q : paused_q;
      play_go  = !p_rise && !paused_q;
    end
  end

  assign bus.paused = paused_q;
`else
  logic p_unused;
  assign p_unused   = bus.P_signal;
  assign play_go    = 1'b1;
  assign bus.paused = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      stage_q  <= STAGE_TITLE;
      target_q <= STAGE_TITLE;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    armed_d  = armed_q | ~bus.stage_clear;
    unique case (state_q)
      IDLE: begin
        if (enter_rise) begin
          if (stage_q == STAGE_TITLE) begin
            stage_d = 4'd1;
            state_d = PLAY;
            start_d = 1'b1;
            armed_d = 1'b0;
          end else begin
            stage_d = STAGE_TITLE;
          end
        end
      end
      PLAY: begin
        if (play_go) begin
          if (bus.lives == 4'd0) begin
            target_d = STAGE_OVER;
            cnt_d    = '0;
            state_d  = HOLD;
          end else if (bus.stage_clear && armed_q) begin
            target_d = (stage_q == LAST_STAGE) ? STAGE_WIN
                                               : stage_q + 4'd1;
            cnt_d    = '0;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_CYCLES - 1'b1) begin
          cnt_d   = '0;
          stage_d = target_q;
          if (is_level(target_q, LAST_STAGE)) begin
            state_d = PLAY;
            start_d = 1'b1;
            armed_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.stage       = stage_q;
  assign bus.stage_start = start_q;
  assign bus.holding     = (state_q == HOLD);

endmodule
